// File: rtl/nebula_muldiv_unit.sv
// rtl/nebula_muldiv_unit.sv - iterative RV32M multiply/divide unit with shared 64-bit datapath
module nebula_muldiv_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [6:0]       op_subcode,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [TAG_W-1:0] op_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_illegal,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [63:0]        acc_q, acc_d;
    logic [31:0]        opnd_q, opnd_d;
    logic [2:0]         f3_q, f3_d;
    logic               neg_q, neg_d;
    logic               sign_a_q, sign_a_d;
    logic [31:0]        res_data_q, res_data_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic               res_illegal_q, res_illegal_d;
    logic               res_valid_q, res_valid_d;

    // Decode of the incoming op. Subcodes 4..11 map onto funct3 order:
    // MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Bit 6 (width) is ignored.
    logic        sub_width_unused;
    logic        legal;
    logic [2:0]  f3;
    logic        signed_a, signed_b, sign_a, sign_b;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, fast;
    logic [31:0] fast_data;

    assign sub_width_unused = op_subcode[6];
    assign legal     = ~op_subcode[5] & (op_subcode[4:0] >= 5'd4) & (op_subcode[4:0] <= 5'd11);
    assign f3        = op_subcode[2:0] + 3'd4;
    assign signed_a  = (f3 == 3'd1) | (f3 == 3'd2) | (f3 == 3'd4) | (f3 == 3'd6);
    assign signed_b  = (f3 == 3'd1) | (f3 == 3'd4) | (f3 == 3'd6);
    assign sign_a    = signed_a & op_a[31];
    assign sign_b    = signed_b & op_b[31];
    assign a_mag     = sign_a ? (32'd0 - op_a) : op_a;
    assign b_mag     = sign_b ? (32'd0 - op_b) : op_b;
    assign div_zero  = legal & f3[2] & (op_b == 32'd0);
    assign div_ovf   = legal & ((f3 == 3'd4) | (f3 == 3'd6))
                     & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
    assign fast      = ~legal | div_zero | div_ovf;

    // Results that need no iteration: illegal op, divide by zero, signed overflow.
    always_comb begin
        fast_data = 32'd0;
        if (!legal) begin
            fast_data = 32'd0;
        end else if (div_zero) begin
            fast_data = f3[1] ? op_a : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            fast_data = f3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration step. Multiply: acc = {partial hi, multiplier lo} shifted
    // right with the multiplicand added when lo[0] is set. Divide: acc =
    // {partial remainder, dividend/quotient} shifted left with a restoring subtract.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_next;

    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next  = {mul_sum, acc_q[31:1]};
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift[31:0] - opnd_q;
    assign div_next  = {(div_ge ? div_sub : div_shift[31:0]), acc_q[30:0], div_ge};

    // Sign restoration and result select performed in FIXUP.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, fix_data;

    assign prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
    assign quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix  = sign_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        fix_data = 32'd0;
        case (f3_q)
            3'd0:                 fix_data = prod_fix[31:0];
            3'd1, 3'd2, 3'd3:     fix_data = prod_fix[63:32];
            3'd4, 3'd5:           fix_data = quo_fix;
            default:              fix_data = rem_fix;
        endcase
    end

    // Next-state logic. res_valid is registered, so it rises one edge after
    // the FSM reaches DONE; flush overrides everything including the handoff.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        f3_d          = f3_q;
        neg_d         = neg_q;
        sign_a_d      = sign_a_q;
        res_data_d    = res_data_q;
        res_tag_d     = res_tag_q;
        res_illegal_d = res_illegal_q;
        res_valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid && op_ready) begin
                    f3_d          = f3;
                    neg_d         = sign_a ^ sign_b;
                    sign_a_d      = sign_a;
                    res_tag_d     = op_tag;
                    res_illegal_d = ~legal;
                    cnt_d         = 5'd31;
                    opnd_d        = f3[2] ? b_mag : a_mag;
                    acc_d         = {32'd0, (f3[2] ? a_mag : b_mag)};
                    if (fast) begin
                        res_data_d = fast_data;
                        state_d    = DONE;
                    end else begin
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = f3_q[2] ? div_next : mul_next;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                res_data_d = fix_data;
                state_d    = DONE;
            end
            DONE: begin
                if (res_valid_q && res_ready) begin
                    state_d = IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 5'd0;
            acc_q         <= 64'd0;
            opnd_q        <= 32'd0;
            f3_q          <= 3'd0;
            neg_q         <= 1'b0;
            sign_a_q      <= 1'b0;
            res_data_q    <= 32'd0;
            res_tag_q     <= '0;
            res_illegal_q <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            f3_q          <= f3_d;
            neg_q         <= neg_d;
            sign_a_q      <= sign_a_d;
            res_data_q    <= res_data_d;
            res_tag_q     <= res_tag_d;
            res_illegal_q <= res_illegal_d;
            res_valid_q   <= res_valid_d;
        end
    end

    assign op_ready    = (state_q == IDLE) & ~flush;
    assign busy        = (state_q != IDLE);
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_tag     = res_tag_q;
    assign res_illegal = res_illegal_q;

endmodule

// File: doc/nebula_muldiv_unit.md
Name: nebula_muldiv_unit

Overview:
- Iterative RV32M execution unit. It receives alu_subcode_e ops from the integer issue stage and returns 32-bit results to writeback.
- Handles IOP_MUL, IOP_MULH, IOP_MULHSU, IOP_MULHU, IOP_DIV, IOP_DIVU, IOP_REM and IOP_REMU.
- Uses a radix-2 shift-add multiplier and a restoring divider sharing one 64-bit datapath.
- Accepts one op at a time over a valid/ready handshake.

Parameters:
- TAG_W, 5, width of destination tag carried alongside the op (rd index).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  abort in-flight op (pipeline squash)
- op_valid  in  1  issue stage presents an op
- op_ready  out  1  unit can accept an op this cycle
- op_subcode  in  7  alu_subcode_e
- op_a  in  32  rs1 operand
- op_b  in  32  rs2 operand
- op_tag  in  TAG_W  destination tag
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts result
- res_data  out  32  result
- res_tag  out  TAG_W  tag of the completed op
- res_illegal  out  1  subcode was not an RV32M op
- busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, op_ready=1, res_valid=0, res_data=0, res_tag=0, res_illegal=0, busy=0.
- Accept condition: op_valid & op_ready. op_ready = (state==IDLE) & ~flush.
- Operand capture: op_a, op_b, op_subcode and op_tag are registered on the accept edge. Inputs after that edge are ignored.
- FSM states: IDLE, CALC, FIXUP, DONE.
- Normal path: IDLE → CALC on accept. CALC runs exactly 32 cycles (5-bit counter, 31 down to 0). CALC → FIXUP when the counter is 0. FIXUP → DONE after 1 cycle.
- Normal latency: res_valid rises 34 edges after the accept edge.
- Fast path: IDLE → DONE directly on accept, so res_valid rises on the next edge. Fast path is taken for:
  - divide by zero (op_b==0, DIV/DIVU/REM/REMU): quotient=0xFFFFFFFF; remainder=op_a.
  - signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): quotient=0x80000000; remainder=0.
  - illegal op (subcode[5]==1, or subcode[4:0] outside 00100..01011): res_data=0, res_illegal=1.
- Subcode bit 6 (width) is ignored; the decoder rejects RV64 forms upstream.
- Signed handling:
  - On accept, operands are converted to magnitudes. Signed: DIV, REM, MULH (both operands); MULHSU (op_a only).
  - Result sign: product/quotient sign = sign_a ^ sign_b. Remainder sign = sign_a.
  - FIXUP performs the conditional two's-complement negation on the 64-bit product, or on the quotient/remainder.
- Multiply result select: MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
- Divide step, per CALC cycle: the partial remainder shifts left one bit and takes the next dividend MSB. If the shifted value ≥ divisor, subtract and set the quotient bit.
- DONE:
  - res_valid=1. res_data, res_tag and res_illegal are held stable until res_valid & res_ready.
  - On that handshake: → IDLE, and res_valid falls on the same edge.
  - op_ready is 0 in DONE, so there is no overlap of a new accept with result handoff.
- flush:
  - In any state: → IDLE on the next edge, res_valid=0, result discarded, no res handshake.
  - op_valid in the same cycle as flush is not accepted.
  - flush outranks res_ready in DONE.
- rst mid-operation: immediate return to reset values. The in-flight op is lost.
- busy = (state != IDLE).

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (−3) → res_data=0xFFFFFFEB, res_valid 34 edges after accept, res_tag echoes op_tag.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Fast path:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - Subcode IOP_ADD → res_illegal=1, res_data=0.
  - Each fast-path case: res_valid exactly 1 edge after accept.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid → res_data/res_tag stable, op_ready=0 throughout. Raising res_ready → IDLE next edge. A back-to-back op is accepted the following cycle.
- Flush and reset:
  - Assert flush at CALC cycle 15 → IDLE next edge, no res_valid pulse.
  - Assert rst asynchronously mid-CALC → all outputs at reset values before the next edge.
  - op_valid with flush=1 → op_ready=0, not accepted.
